alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
Upstream issue stage for the 16-bit ArithmeticLogicUnit. It holds a small operand register file and accepts ALU requests over a valid/ready handshake. For each request it drives the ALU A/B/FunSel/WF inputs for exactly one cycle, writes the ALU result back to a destination register, and reports the result together with the post-operation flags. It also accepts direct register loads from the datapath.

Parameters:
NUM_REGS, 4, number of operand registers (R0..R3); register index width is $clog2(NUM_REGS)
DATA_W, 16, operand/result width; must match the ALU

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
ReqValid  in  1  request present
ReqReady  out  1  sequencer can accept a request
ReqFunSel  in  5  ALU function for the request
ReqSrcA  in  2  register index for operand A
ReqSrcB  in  2  register index for operand B
ReqDst  in  2  destination register index
ReqWF  in  1  request updates ALU flags
LoadEn  in  1  direct register load strobe
LoadSel  in  2  register index for the direct load
LoadData  in  16  data for the direct load
AluA  out  16  to ALU A
AluB  out  16  to ALU B
AluFunSel  out  5  to ALU FunSel
AluWF  out  1  to ALU WF
AluOut  in  16  from ALU ALUOut
AluFlags  in  4  from ALU FlagsOut: {Z,C,N,O} = bits [3:0]
DoneValid  out  1  one-cycle completion pulse
DoneData  out  16  written-back result
DoneFlags  out  4  ALU flags after the operation

Behaviour:
- FSM states: IDLE, EXEC, FLAG.
  - IDLE -> EXEC on ReqValid & ReqReady.
  - EXEC -> FLAG unconditionally.
  - FLAG -> IDLE unconditionally.
- ReqReady = 1 only in IDLE (combinational from state).
- Acceptance: on the accepting edge, latch FunSel, SrcA, SrcB, Dst and WF. Operands are read from the register file during EXEC, so a load landing on the accept edge is seen.
- EXEC outputs:
  - AluA = R[SrcA], AluB = R[SrcB], AluFunSel = latched FunSel.
  - AluWF = latched WF, asserted in EXEC only.
  - At the end of EXEC, write AluOut to R[Dst], because the ALU latches its flags on that same edge.
- Width rule for writeback:
  - FunSel[4] = 0 (8-bit op): write {8'h00, AluOut[7:0]}.
  - FunSel[4] = 1: write the full AluOut.
- FLAG state:
  - AluWF = 0; AluA, AluB and AluFunSel hold their EXEC values.
  - At the end of FLAG, register DoneFlags <= AluFlags and DoneData <= the written-back value, and set DoneValid.
- Outside EXEC/FLAG: AluA, AluB, AluFunSel and AluWF are 0 (AluFunSel = 5'b00000).
- DoneValid is high for exactly one cycle, the IDLE cycle after FLAG.
- Latency: accept edge T0 -> EXEC T1 -> FLAG T2 -> DoneValid T3. A new request can be accepted in T3. Throughput is 1 operation per 3 cycles.
- Src = Dst is legal: the old value is used as the operand and the new value is written.
- Direct load is accepted in any state. If a load and the EXEC writeback hit the same register on the same edge, the writeback wins. Different registers are both written.
- WF = 0: DoneFlags still reports AluFlags, which are unchanged by the operation.
- Reset (async, active-low), including mid-operation:
  - All registers = 0 and state = IDLE; any in-flight op is dropped with no DoneValid.
  - All outputs = 0, except ReqReady = 1 once Reset is released.
  - ALU flags are not touched.

Optional Feature:
ALU_SEQ_IMM_EN
- Defined: adds ports ReqImmSel (in, 1) and ReqImm (in, 16), both latched on accept. If ReqImmSel = 1, AluB = latched ReqImm and SrcB is ignored.
- Undefined: these ports do not exist and AluB always comes from R[SrcB].

Test Plan:
- Load R0 = 0x1234, R1 = 0x00FF; request FunSel 10100, A = R0, B = R1, Dst = R2, WF = 1 -> DoneValid at T3, DoneData = 0x1333, DoneFlags = 4'b0000, R2 = 0x1333.
- 8-bit add FunSel 00100, A = B = R1 (0x00FF), Dst = R3, WF = 1 -> DoneData = 0x00FE, DoneFlags = 4'b0110 (C = 1, N = 1), R3 = 0x00FE.
- Subtract FunSel 10110, A = B = R0 (0x1234), WF = 0 -> DoneData = 0x0000, DoneFlags equal to the pre-op flags; AluWF stays 0 in every cycle.
- LoadEn with LoadSel = Dst = R2 and LoadData = 0xAAAA on the EXEC edge of 16-bit A = R0 (0x1234) -> R2 = result 0x1234. Repeat with LoadSel = R1 -> R1 = 0xAAAA and R2 = result.
- ReqValid held high continuously -> ReqReady pattern 1,0,0,1,0,0…; back-to-back ops complete in order; DoneValid never high for 2 consecutive cycles.
- Reset asserted during FLAG -> no DoneValid, R0..R3 = 0, ReqReady = 1 one cycle after Reset deasserts.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Issue stage for the 16-bit ALU: small operand register file, valid/ready request port,
// three-cycle IDLE/EXEC/FLAG sequence. Optional immediate operand B under `ALU_SEQ_IMM_EN`.
module alu_operand_sequencer #(
   parameter int  NUM_REGS = 4,
   parameter int  DATA_W   = 16,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [4:0]        i_req_fun_sel,
   input  logic [IDX_W-1:0]  i_req_src_a,
   input  logic [IDX_W-1:0]  i_req_src_b,
   input  logic [IDX_W-1:0]  i_req_dst,
   input  logic              i_req_wf,
`ifdef ALU_SEQ_IMM_EN
   input  logic              i_req_imm_sel,
   input  logic [DATA_W-1:0] i_req_imm,
`endif
   input  logic              i_load_en,
   input  logic [IDX_W-1:0]  i_load_sel,
   input  logic [DATA_W-1:0] i_load_data,
   output logic [DATA_W-1:0] o_alu_a,
   output logic [DATA_W-1:0] o_alu_b,
   output logic [4:0]        o_alu_fun_sel,
   output logic              o_alu_wf,
   input  logic [DATA_W-1:0] i_alu_out,
   input  logic [3:0]        i_alu_flags,
   output logic              o_done_valid,
   output logic [DATA_W-1:0] o_done_data,
   output logic [3:0]        o_done_flags
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FLAG} state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [4:0]          r_alu_fun_sel;
   logic                r_alu_wf;
   logic [IDX_W-1:0]    r_dst;
   logic [DATA_W-1:0]   r_wb_data;
   logic                r_done_valid;
   logic [DATA_W-1:0]   r_done_data;
   logic [3:0]          r_done_flags;

   logic                w_accept;
   logic                w_wb_en;
   logic [DATA_W-1:0]   w_wb_data;
   logic [DATA_W-1:0]   w_opnd_a;
   logic [DATA_W-1:0]   w_opnd_b;
   logic [DATA_W-1:0]   w_reg_next [NUM_REGS];

   assign o_req_ready = (r_state == S_IDLE) && i_rst_n;
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_wb_en     = (r_state == S_EXEC);

   // 8-bit operations only own the low byte of the destination
   assign w_wb_data = r_alu_fun_sel[4] ? i_alu_out
                                       : {{(DATA_W-8){1'b0}}, i_alu_out[7:0]};

   // Operands are captured with any load landing on the accept edge already applied
   assign w_opnd_a = (i_load_en && (i_load_sel == i_req_src_a)) ? i_load_data
                                                                 : r_regs[i_req_src_a];
`ifdef ALU_SEQ_IMM_EN
   assign w_opnd_b = i_req_imm_sel ? i_req_imm
                   : (i_load_en && (i_load_sel == i_req_src_b)) ? i_load_data
                                                                : r_regs[i_req_src_b];
`else
   assign w_opnd_b = (i_load_en && (i_load_sel == i_req_src_b)) ? i_load_data
                                                                : r_regs[i_req_src_b];
`endif

   // Writeback has priority over a direct load to the same register
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_next
         assign w_reg_next[gi] =
            (w_wb_en && (r_dst == IDX_W'(gi)))         ? w_wb_data   :
            (i_load_en && (i_load_sel == IDX_W'(gi)))  ? i_load_data :
                                                         r_regs[gi];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_reg_next[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_fun_sel <= '0;
         r_alu_wf      <= 1'b0;
         r_dst         <= '0;
         r_wb_data     <= '0;
         r_done_valid  <= 1'b0;
         r_done_data   <= '0;
         r_done_flags  <= '0;
      end else begin
         r_done_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state       <= S_EXEC;
                  r_alu_a       <= w_opnd_a;
                  r_alu_b       <= w_opnd_b;
                  r_alu_fun_sel <= i_req_fun_sel;
                  r_alu_wf      <= i_req_wf;
                  r_dst         <= i_req_dst;
               end
            end
            S_EXEC: begin
               r_state   <= S_FLAG;
               r_alu_wf  <= 1'b0;
               r_wb_data <= w_wb_data;
            end
            S_FLAG: begin
               // ALU flags latched on the EXEC edge are visible now
               r_state       <= S_IDLE;
               r_alu_a       <= '0;
               r_alu_b       <= '0;
               r_alu_fun_sel <= '0;
               r_done_valid  <= 1'b1;
               r_done_data   <= r_wb_data;
               r_done_flags  <= i_alu_flags;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_alu_fun_sel = r_alu_fun_sel;
   assign o_alu_wf      = r_alu_wf;
   assign o_done_valid  = r_done_valid;
   assign o_done_data   = r_done_data;
   assign o_done_flags  = r_done_flags;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: ALU stub, occupancy-based reference model checked every cycle,
// plus directed operations with hand-computed results.
`timescale 1ns/1ps
module tb_alu_operand_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_fun = '0;
   logic [1:0]  req_sa = '0, req_sb = '0, req_dst = '0;
   logic        req_wf = 1'b0;
   logic        load_en = 1'b0;
   logic [1:0]  load_sel = '0;
   logic [15:0] load_data = '0;
   logic [15:0] alu_a, alu_b, alu_out, done_data;
   logic [4:0]  alu_fun;
   logic        alu_wf, done_valid;
   logic [3:0]  stub_flags = 4'b0000;
   logic [3:0]  done_flags;
   logic [19:0] stub_calc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_fun_sel(req_fun), .i_req_src_a(req_sa), .i_req_src_b(req_sb),
      .i_req_dst(req_dst), .i_req_wf(req_wf),
`ifdef ALU_SEQ_IMM_EN
      .i_req_imm_sel(1'b0), .i_req_imm(16'h0000),
`endif
      .i_load_en(load_en), .i_load_sel(load_sel), .i_load_data(load_data),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun_sel(alu_fun), .o_alu_wf(alu_wf),
      .i_alu_out(alu_out), .i_alu_flags(stub_flags),
      .o_done_valid(done_valid), .o_done_data(done_data), .o_done_flags(done_flags)
   );

   // Reference ALU: pass-A, add, subtract; 8-bit ops return the full 16-bit sum so the
   // sequencer's byte masking is exercised. Returns {Z,C,N,O, out}.
   function automatic logic [19:0] alu_ref(input logic [4:0] fun, input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] s16;
      logic [8:0]  s8;
      logic        sub, arith, z, c, n, o, bs;
      sub   = (fun[3:0] == 4'b0110);
      arith = (fun[3:0] == 4'b0100) || sub;
      if (sub) begin
         s16 = {1'b0, a} + {1'b0, ~b} + 17'd1;
         s8  = {1'b0, a[7:0]} + {1'b0, ~b[7:0]} + 9'd1;
      end else if (arith) begin
         s16 = {1'b0, a} + {1'b0, b};
         s8  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
      end else begin
         s16 = {1'b0, a};
         s8  = {1'b0, a[7:0]};
      end
      if (fun[4]) begin
         bs = sub ? ~b[15] : b[15];
         z = (s16[15:0] == 16'h0); c = arith & s16[16]; n = s16[15];
         o = arith & (a[15] == bs) & (s16[15] != a[15]);
      end else begin
         bs = sub ? ~b[7] : b[7];
         z = (s8[7:0] == 8'h0); c = arith & s8[8]; n = s8[7];
         o = arith & (a[7] == bs) & (s8[7] != a[7]);
      end
      return {z, c, n, o, s16[15:0]};
   endfunction

   // ALU stub: combinational result, flags latched when WF is high (never reset)
   always_comb stub_calc = alu_ref(alu_fun, alu_a, alu_b);
   assign alu_out = stub_calc[15:0];
   always @(posedge clk) if (alu_wf) stub_flags <= stub_calc[19:16];

   // Reference model: an accepted op occupies the two following cycles, then reports
   logic [15:0] m_regs [4];
   logic [1:0]  m_busy = 2'd0;
   logic [15:0] m_a = '0, m_b = '0, m_wb = '0;
   logic [4:0]  m_fun = '0;
   logic        m_wf = 1'b0;
   logic [1:0]  m_dst = '0;
   logic [3:0]  m_flags = 4'b0000;
   logic        exp_dv = 1'b0;
   logic [15:0] exp_dd = '0;
   logic [3:0]  exp_df = '0;
   logic [15:0] t_ra, t_rb, t_wb;
   logic [19:0] t_calc;

   always_comb begin
      t_ra   = (load_en && load_sel == req_sa) ? load_data : m_regs[req_sa];
      t_rb   = (load_en && load_sel == req_sb) ? load_data : m_regs[req_sb];
      t_calc = alu_ref(m_fun, m_a, m_b);
      t_wb   = m_fun[4] ? t_calc[15:0] : {8'h00, t_calc[7:0]};
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) m_regs[i] <= 16'h0;
         m_busy <= 2'd0;
         exp_dv <= 1'b0;
      end else begin
         exp_dv <= 1'b0;
         if (load_en) m_regs[load_sel] <= load_data;
         if (m_busy == 2'd2) begin
            m_regs[m_dst] <= t_wb;
            m_wb          <= t_wb;
            if (m_wf) m_flags <= t_calc[19:16];
            m_busy <= 2'd1;
         end else if (m_busy == 2'd1) begin
            exp_dv <= 1'b1;
            exp_dd <= m_wb;
            exp_df <= m_flags;
            m_busy <= 2'd0;
         end else if (req_valid) begin
            m_a <= t_ra; m_b <= t_rb; m_fun <= req_fun; m_wf <= req_wf; m_dst <= req_dst;
            m_busy <= 2'd2;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic prev_dv = 1'b0;
   always @(negedge clk) begin
      chk("ready", {31'b0, req_ready}, {31'b0, (m_busy == 2'd0) && rst_n});
      chk("alu_a", {16'b0, alu_a}, {16'b0, (m_busy != 0) ? m_a : 16'h0});
      chk("alu_b", {16'b0, alu_b}, {16'b0, (m_busy != 0) ? m_b : 16'h0});
      chk("alu_fun", {27'b0, alu_fun}, {27'b0, (m_busy != 0) ? m_fun : 5'h0});
      chk("alu_wf", {31'b0, alu_wf}, {31'b0, (m_busy == 2'd2) && m_wf});
      chk("done_valid", {31'b0, done_valid}, {31'b0, exp_dv});
      if (exp_dv) begin
         chk("done_data", {16'b0, done_data}, {16'b0, exp_dd});
         chk("done_flags", {28'b0, done_flags}, {28'b0, exp_df});
      end
      if (prev_dv) chk("done_not_double", {31'b0, done_valid}, 32'd0);
      prev_dv = done_valid;
   end

   task automatic do_load(input logic [1:0] sel, input logic [15:0] data);
      @(posedge clk); #1;
      load_en = 1'b1; load_sel = sel; load_data = data;
      @(posedge clk); #1;
      load_en = 1'b0;
      $display("load R%0d <= %h", sel, data);
   endtask

   // One request; optional direct load pulsed during the EXEC cycle
   task automatic run_op(input logic [4:0] fun, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [1:0] d, input logic wf, input logic ld,
                         input logic [1:0] ld_sel, input logic [15:0] ld_data,
                         output logic [15:0] data, output logic [3:0] flags);
      @(posedge clk); #1;
      req_fun = fun; req_sa = sa; req_sb = sb; req_dst = d; req_wf = wf; req_valid = 1'b1;
      for (int i = 0; i < 10 && !req_ready; i++) begin @(posedge clk); #1; end
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (ld) begin
         load_en = 1'b1; load_sel = ld_sel; load_data = ld_data;
         @(posedge clk); #1;
         load_en = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done_valid) break;
      end
      chk("done_timeout", {31'b0, done_valid}, 32'd1);
      data = done_data; flags = done_flags;
      $display("op fun=%b A=R%0d B=R%0d dst=R%0d wf=%0d -> data=%h flags=%b",
               fun, sa, sb, d, wf, data, flags);
   endtask

   task automatic rd_reg(input logic [1:0] r, input logic [15:0] exp, input string name);
      logic [15:0] d;
      logic [3:0]  f;
      run_op(5'b10000, r, r, r, 1'b0, 1'b0, 2'd0, 16'h0, d, f);
      chk(name, {16'b0, d}, {16'b0, exp});
   endtask

   logic [15:0] d;
   logic [3:0]  f;

   initial begin
      #23;
      chk("rst_ready_low", {31'b0, req_ready}, 32'd0);
      chk("rst_done_valid", {31'b0, done_valid}, 32'd0);
      chk("rst_done_data", {16'b0, done_data}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready_high", {31'b0, req_ready}, 32'd1);

      do_load(2'd0, 16'h1234);
      do_load(2'd1, 16'h00FF);

      run_op(5'b10100, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, 16'h0, d, f);
      chk("add16_data", {16'b0, d}, 32'h1333);
      chk("add16_flags", {28'b0, f}, 32'h0);
      rd_reg(2'd2, 16'h1333, "rd_r2_add16");

      run_op(5'b00100, 2'd1, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0, 16'h0, d, f);
      chk("add8_data", {16'b0, d}, 32'h00FE);
      chk("add8_flags", {28'b0, f}, 32'h6);
      rd_reg(2'd3, 16'h00FE, "rd_r3_add8");

      run_op(5'b10110, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 16'h0, d, f);
      chk("sub_nowf_data", {16'b0, d}, 32'h0);
      chk("sub_nowf_flags", {28'b0, f}, 32'h6);

      run_op(5'b10000, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1, 2'd2, 16'hAAAA, d, f);
      chk("wb_beats_load", {16'b0, d}, 32'h1234);
      rd_reg(2'd2, 16'h1234, "rd_r2_collide");

      run_op(5'b10000, 2'd0, 2'd0, 2'd2, 1'b0, 1'b1, 2'd1, 16'hAAAA, d, f);
      rd_reg(2'd1, 16'hAAAA, "rd_r1_load");
      rd_reg(2'd2, 16'h1234, "rd_r2_both");

      run_op(5'b10100, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 16'h0, d, f);
      chk("src_eq_dst_data", {16'b0, d}, 32'hBCDE);
      chk("src_eq_dst_flags", {28'b0, f}, 32'h2);
      rd_reg(2'd0, 16'hBCDE, "rd_r0_srcdst");

      // Request held continuously: three back-to-back accumulations into R0
      @(posedge clk); #1;
      req_fun = 5'b10100; req_sa = 2'd0; req_sb = 2'd1; req_dst = 2'd0; req_wf = 1'b0;
      req_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk("ready_pattern", {31'b0, req_ready}, {31'b0, (k % 3) == 0});
         if (k == 8) req_valid = 1'b0;
         @(posedge clk); #1;
      end
      $display("b2b three ops R0 += R1 issued");
      repeat (2) @(posedge clk);
      rd_reg(2'd0, 16'hBCDC, "rd_r0_b2b");

      // Reset in the FLAG cycle drops the op
      @(posedge clk); #1;
      req_fun = 5'b10100; req_sa = 2'd0; req_sb = 2'd1; req_dst = 2'd2; req_wf = 1'b1;
      req_valid = 1'b1;
      chk("rstflag_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstflag_alu_a", {16'b0, alu_a}, 32'd0);
      chk("rstflag_ready_low", {31'b0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rstflag_ready_after", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstflag_no_done", {31'b0, done_valid}, 32'd0);
      end
      $display("reset during FLAG applied");
      for (int r = 0; r < 4; r++) rd_reg(2'(r), 16'h0, "rd_after_rst");

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
